// File: rtl/master_return_fifo.sv
// Per-master return-path buffer: pops the arbiter-granted slave return FIFO,
// stores responses in order and presents them to the master with valid/ready.
module master_return_fifo #(
  parameter int unsigned masters    = 2,
  parameter int unsigned slaves     = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                                         ACLK,
  input  logic                                         ARESETn,
  input  logic                                         push_to_fifo,
  input  logic [((slaves > 1) ? $clog2(slaves) : 1)-1:0] grant_slave_number,
  input  logic [DATA_WIDTH-1:0]                        slave_payload [0:slaves-1],
  output logic [slaves-1:0]                            slave_fifo_pop,
  output logic                                         master_fifo_full,
  output logic                                         master_valid,
  output logic [DATA_WIDTH-1:0]                        master_payload,
  input  logic                                         master_ready,
  output logic [$clog2(DEPTH):0]                       fifo_count,
  output logic                                         push_drop_err
);

  localparam int unsigned GW = (slaves > 1) ? $clog2(slaves) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // With a power-of-two slave count every grant encoding is a real slave.
  localparam bit GRANT_FULL_RANGE = (slaves == (32'd1 << GW));

  // Elaboration guard on the configuration.
  if (masters == 0 || slaves == 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("master_return_fifo: invalid parameter set");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  drop_err;
  logic                  grant_ok;
  logic                  push_ok;
  logic                  pop_ok;
  logic [DATA_WIDTH-1:0] wr_data;

  assign master_fifo_full = (count == CW'(DEPTH));
  assign master_valid     = (count != '0);
  assign master_payload   = master_valid ? mem[rd_ptr] : '0;
  assign fifo_count       = count;
  assign push_drop_err    = drop_err;

  // Push qualification, slave pop strobe and write-data select.
  always_comb begin
    grant_ok       = GRANT_FULL_RANGE ? 1'b1
                   : ({{(32-GW){1'b0}}, grant_slave_number} < slaves);
    push_ok        = ARESETn & push_to_fifo & ~master_fifo_full & grant_ok;
    pop_ok         = master_valid & master_ready;
    slave_fifo_pop = '0;
    wr_data        = '0;
    for (int unsigned i = 0; i < slaves; i++) begin
      if (grant_slave_number == GW'(i)) begin
        slave_fifo_pop[i] = push_ok;
        wr_data           = slave_payload[i];
      end
    end
  end

  // Storage array is not reset; stale contents are masked by master_valid.
  always_ff @(posedge ACLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky drop diagnostic.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_to_fifo & (master_fifo_full | ~grant_ok)) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_master_return_fifo.sv
// Randomized and directed bench for master_return_fifo against a queue model
// (three slaves so the invalid-grant path exists, DEPTH = 4).
module tb_master_return_fifo;

  localparam int unsigned SLAVES = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DW     = 32;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [1:0]    grant;
  logic [DW-1:0] pl [0:SLAVES-1];
  logic [SLAVES-1:0] pop;
  logic          full;
  logic          valid;
  logic [DW-1:0] payload;
  logic          ready;
  logic [2:0]    count;
  logic          err;

  master_return_fifo #(
    .masters(2), .slaves(SLAVES), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .ACLK(clk),
    .ARESETn(rst_n),
    .push_to_fifo(push),
    .grant_slave_number(grant),
    .slave_payload(pl),
    .slave_fifo_pop(pop),
    .master_fifo_full(full),
    .master_valid(valid),
    .master_payload(payload),
    .master_ready(ready),
    .fifo_count(count),
    .push_drop_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [DW-1:0] model_q[$];
  bit            model_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive after the falling edge, check before the rising edge,
  // then advance the model with what the rules say must happen at that edge.
  task automatic step(input bit p, input logic [1:0] g, input bit r, input logic [DW-1:0] d);
    bit            p_ok;
    bit            r_ok;
    logic [DW-1:0] exp_pl;
    logic [DW-1:0] pushed;
    push  = p;
    grant = g;
    ready = r;
    for (int i = 0; i < SLAVES; i++) pl[i] = $urandom;
    if (g < SLAVES) pl[g] = d;
    #1;
    p_ok   = p && (model_q.size() < DEPTH) && (g < SLAVES);
    r_ok   = r && (model_q.size() > 0);
    exp_pl = (model_q.size() > 0) ? model_q[0] : '0;
    pushed = (g < SLAVES) ? pl[g] : '0;
    check("valid", valid, model_q.size() > 0);
    check("payload", payload, exp_pl);
    check("count", count, model_q.size());
    check("full", full, model_q.size() == DEPTH);
    check("pop", pop, p_ok ? (3'b001 << g) : 3'b000);
    check("drop_err", err, model_err);
    @(posedge clk);
    if (p && (model_q.size() == DEPTH || g >= SLAVES)) model_err = 1'b1;
    if (r_ok) void'(model_q.pop_front());
    if (p_ok) model_q.push_back(pushed);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    grant = '0;
    ready = 1'b0;
    for (int i = 0; i < SLAVES; i++) pl[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_full", full, 1'b0);
    check("rst_payload", payload, 32'h0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;

    // Basic latency: single push from slave 1 into an empty buffer.
    step(1'b1, 2'd1, 1'b0, 32'hA5);
    check("lat_valid", valid, 1'b1);
    check("lat_payload", payload, 32'hA5);
    check("lat_count", count, 3'd1);
    step(1'b0, 2'd0, 1'b1, 32'h0);

    // Fill with 1..4 from alternating slaves, then hold push while full.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i % 2), 1'b0, 32'(i + 1));
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i % 3), 1'b0, 32'hDEAD);
    check("fill_full", full, 1'b1);
    check("fill_count", count, 3'd4);
    check("fill_err", err, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b1, 32'h0);

    // Full with simultaneous pop and push: pop wins, push lands next cycle.
    for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 1'b0, 32'h100 + 32'(i));
    step(1'b1, 2'd0, 1'b1, 32'hBB);
    check("fp_count3", count, 3'd3);
    step(1'b1, 2'd1, 1'b0, 32'hCC);
    check("fp_count4", count, 3'd4);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b1, 32'h0);

    // Pointer wrap: steady push+pop at occupancy 2.
    step(1'b1, 2'd0, 1'b0, 32'h200);
    step(1'b1, 2'd1, 1'b0, 32'h201);
    for (int i = 0; i < 10; i++) step(1'b1, 2'(i % 3), 1'b1, 32'h300 + 32'(i));
    check("wrap_count", count, 3'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, 32'h0);

    // Invalid grant: no pop, count unchanged, sticky error.
    step(1'b1, 2'd3, 1'b0, 32'h0);
    check("inv_err", err, 1'b1);
    check("inv_count", count, 3'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);

    // Reset mid-stream after three pushes, between clock edges.
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b1, 32'h0);
    step(1'b1, 2'd3, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), 1'b0, 32'h400 + 32'(i));
    push  = 1'b1;
    grant = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid", valid, 1'b0);
    check("mid_count", count, 3'd0);
    check("mid_err", err, 1'b0);
    check("mid_pop", pop, 3'b000);
    check("mid_payload", payload, 32'h0);
    model_q.delete();
    model_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'd2, 1'b0, 32'h777);
    step(1'b0, 2'd0, 1'b0, 32'h0);
    check("post_count", count, 3'd1);
    check("post_payload", payload, 32'h777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/master_return_fifo.md
Name: master_return_fifo

Overview:
Per-master return-path buffer in the crossbar backward path. It sits directly downstream of the backward arbiter. It consumes the arbiter's push request and granted slave number, pops that slave's return FIFO, and stores the payload. It then presents stored responses to the master port with a valid/ready handshake and reports full back to the arbiter.

Parameters:
masters, 2, number of masters in the crossbar (width bookkeeping only)
slaves, 2, number of slave return FIFOs feeding this block
DATA_WIDTH, 32, response payload width (data + resp + id bits, opaque here)
DEPTH, 4, entries; must be a power of two, >= 2

Ports:
ACLK  input  1  clock, all state on rising edge
ARESETn  input  1  reset, asynchronous, active-low
push_to_fifo  input  1  arbiter requests a push from the granted slave
grant_slave_number  input  $clog2(slaves)  slave index selected by the arbiter
slave_payload  input  DATA_WIDTH x [0:slaves-1]  head entry of each slave return FIFO
slave_fifo_pop  output  1 x [0:slaves-1]  pop strobe to each slave return FIFO
master_fifo_full  output  1  buffer full, fed back to the arbiter
master_valid  output  1  response available to the master
master_payload  output  DATA_WIDTH  head response
master_ready  input  1  master accepts the response
fifo_count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH
push_drop_err  output  1  sticky: push requested while full or with an invalid grant

Behaviour:
- Storage: DEPTH x DATA_WIDTH array.
  - Write pointer and read pointer, each $clog2(DEPTH) bits; both wrap naturally from DEPTH-1 to 0.
  - Separate count register, $clog2(DEPTH)+1 bits.
- push_ok = push_to_fifo & ~master_fifo_full & (grant_slave_number < slaves).
- On push_ok, the same cycle:
  - slave_fifo_pop[grant_slave_number] = 1 (combinational); all other pop bits are 0.
  - slave_payload[grant] is written to mem[wr_ptr] at the clock edge; wr_ptr increments.
- When push_ok = 0, all slave_fifo_pop bits are 0. The upstream arbiter may hold push_to_fifo high while full; the block must never pop a slave in that case.
- pop_ok = master_valid & master_ready; rd_ptr increments at the edge.
- count next value: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- master_fifo_full = (count == DEPTH), combinational from the count register.
  - No same-cycle bypass: a pop while full does not permit a push that cycle.
- master_valid = (count != 0).
- master_payload = mem[rd_ptr] when master_valid, else all zeros.
- Latency: a push into an empty buffer gives master_valid = 1 on the next cycle (1-cycle latency). There is no empty-path bypass.
- Handshake: master_payload holds stable while master_valid & ~master_ready. A ready with no valid has no effect.
- Simultaneous push and pop with count in 1..DEPTH-1: both happen, count unchanged, pointers both advance.
- push_drop_err:
  - Sets on any cycle with push_to_fifo & (master_fifo_full | grant >= slaves).
  - Stays set until reset. Diagnostic only; it does not affect data flow.
- Order is strict FIFO: responses leave in push order regardless of source slave.
- Reset (ARESETn low, any time, asynchronous):
  - Pointers, count and push_drop_err go to 0.
  - Output values: master_valid = 0, master_payload = 0, master_fifo_full = 0, fifo_count = 0, slave_fifo_pop all 0.
  - Memory contents are not cleared (they are masked by valid).
  - A push or pop in flight at reset is lost. No pop strobe may be emitted while ARESETn is low.
- masters is unused in logic. grant_slave_number is range-checked only when slaves is not a power of two.

Test Plan:
- Reset mid-stream:
  - Stimulus: after 3 pushes, assert ARESETn = 0 between edges.
  - Required: master_valid, fifo_count and push_drop_err drop to 0 immediately, before the next edge.
  - Required: after release, the first new push appears alone.
- Basic latency:
  - Stimulus: empty buffer, DEPTH = 4, master_ready = 0; one cycle push_to_fifo = 1, grant = 1, slave_payload[1] = 0xA5.
  - Required: slave_fifo_pop = 2'b10 that cycle; next cycle master_valid = 1, master_payload = 0xA5, fifo_count = 1.
- Fill and hold-off:
  - Stimulus: 4 pushes (payloads 1,2,3,4 from alternating slaves), master_ready = 0, then push_to_fifo held high.
  - Required: master_fifo_full = 1 and fifo_count = 4; no pop strobe; push_drop_err = 1.
  - Required: then ready = 1 drains 1,2,3,4 in order.
- Full plus pop same cycle:
  - Stimulus: full, master_ready = 1 and push_to_fifo = 1 together.
  - Required: the pop occurs and the push is rejected; count goes to 3.
  - Required: the next cycle's push is accepted and count returns to 4.
- Pointer wrap:
  - Stimulus: 10 consecutive push + pop cycles at count = 2.
  - Required: count stays 2; output sequence equals input sequence; no data corruption across index 3->0.
- Invalid grant:
  - Stimulus: slaves = 3, grant = 3 with push_to_fifo = 1.
  - Required: no pop, count unchanged, push_drop_err = 1.
